// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FPU normalization datapath.
//   - field widths of the internal operand and the extended-format result
//   - FSM state and per-step terminal-code enums
//   - extended-format limits (max exponent, integer-bit position)
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int EXP_W   = 17;  // two's-complement working exponent
  localparam int MANT_W  = 68;  // carry | integer | fraction(63) | g r s
  localparam int OUT_W   = 80;  // extended precision: sign, exp15, sig64
  localparam int XEXP_W  = 15;
  localparam int SIG_W   = 64;

  localparam int EXT_CARRY_BIT = 67;
  localparam int EXT_INT_BIT   = 66;

  localparam logic [XEXP_W-1:0] EXT_EXP_MAX  = 15'h7FFF;
  localparam logic [SIG_W-1:0]  EXT_SIG_INF  = 64'h8000_0000_0000_0000;

  // Working exponent thresholds.
  localparam logic signed [EXP_W-1:0] EXP_ONE  = 17'sd1;
  localparam logic signed [EXP_W-1:0] EXP_OVF  = 17'sd32767;
  // Below this, every right shift up to exp=1 would push all bits into
  // sticky, so the whole walk collapses into a single step.
  localparam logic signed [EXP_W-1:0] EXP_TINY = -17'sd70;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

  typedef enum logic [2:0] {
    TERM_NONE   = 3'd0,  // a shift was taken, keep iterating
    TERM_ZERO   = 3'd1,
    TERM_OVF    = 3'd2,
    TERM_NORM   = 3'd3,
    TERM_DENORM = 3'd4
  } norm_term_e;

  typedef struct packed {
    logic              sign;
    logic [XEXP_W-1:0] exp;
    logic [SIG_W-1:0]  sig;
  } ext_fp_t;

endpackage

// File: rtl/fpu_norm_step.sv
// ---------------------------------------------------------------------------
// fpu_norm_step
// One combinational normalization step. Given the working mantissa and
// exponent it applies the first matching rule of the step priority list
// and reports either the shifted operand (TERM_NONE) or a terminal class.
//   mant_i / exp_i  : current working mantissa / signed exponent
//   mant_o / exp_o  : value after this step (unchanged on a terminal code)
//   term_o          : TERM_NONE or the result class
// Optional feature: `FPU_NORM_COARSE_SHIFT_EN enables the coarse left
// shift by COARSE_STEP; without it COARSE_STEP only feeds the range check.
// ---------------------------------------------------------------------------
module fpu_norm_step
  import fpu_pkg::*;
#(
  parameter int COARSE_STEP = 8
) (
  input  logic        [MANT_W-1:0] mant_i,
  input  logic signed [EXP_W-1:0]  exp_i,
  output logic        [MANT_W-1:0] mant_o,
  output logic signed [EXP_W-1:0]  exp_o,
  output norm_term_e               term_o
);

  // The coarse window must fit under the integer bit.
  if (COARSE_STEP < 1 || COARSE_STEP > EXT_INT_BIT) begin : g_bad_coarse
    $error("fpu_norm_step: COARSE_STEP out of range");
  end

  // Right shift by one, folding the two lowest bits into sticky.
  logic [MANT_W-1:0] mant_rsh;
  assign mant_rsh = {1'b0, mant_i[MANT_W-1:2], mant_i[1] | mant_i[0]};

`ifdef FPU_NORM_COARSE_SHIFT_EN
  localparam logic signed [EXP_W-1:0] EXP_COARSE = EXP_W'(COARSE_STEP);
  logic coarse_ok;
  assign coarse_ok = (mant_i[EXT_INT_BIT -: COARSE_STEP] == '0) &&
                     (exp_i > EXP_COARSE);
`endif

  always_comb begin
    mant_o = mant_i;
    exp_o  = exp_i;
    term_o = TERM_NONE;
    if (mant_i == '0) begin
      term_o = TERM_ZERO;
    end else if (mant_i[EXT_CARRY_BIT]) begin
      mant_o = mant_rsh;
      exp_o  = exp_i + EXP_ONE;
    end else if (exp_i < EXP_ONE) begin
      if (exp_i < EXP_TINY) begin
        mant_o = {{(MANT_W-1){1'b0}}, |mant_i};
        exp_o  = EXP_ONE;
      end else begin
        mant_o = mant_rsh;
        exp_o  = exp_i + EXP_ONE;
      end
    end else if (exp_i >= EXP_OVF) begin
      term_o = TERM_OVF;
    end else if (mant_i[EXT_INT_BIT]) begin
      term_o = TERM_NORM;
`ifdef FPU_NORM_COARSE_SHIFT_EN
    end else if (coarse_ok) begin
      mant_o = mant_i << COARSE_STEP;
      exp_o  = exp_i - EXP_COARSE;
`endif
    end else if (exp_i == EXP_ONE) begin
      term_o = TERM_DENORM;
    end else begin
      mant_o = mant_i << 1;
      exp_o  = exp_i - EXP_ONE;
    end
  end

endmodule

// File: rtl/fpu_normalize_unit.sv
// ---------------------------------------------------------------------------
// fpu_normalize_unit
// Iterative normalizer: accepts one unnormalized operand (68-bit mantissa
// with carry, integer, fraction and G/R/S bits plus a 17-bit signed biased
// exponent) and produces an 80-bit extended-format value with final GRS
// bits and zero/denormal/overflow flags. One fpu_norm_step per cycle.
//   clk, reset_n            : clock, synchronous active-low reset
//   in_valid/in_ready       : operand handshake (ready only in IDLE)
//   in_sign/exponent/mantissa: operand
//   out_valid/out_ready     : result handshake (valid only in DONE)
//   out_data, out_grs       : {sign, exp15, sig64}, guard/round/sticky
//   out_zero/denormal/overflow: result class
// Optional feature: `FPU_NORM_COARSE_SHIFT_EN (coarse left shift of
// COARSE_STEP bits); results are identical either way, only latency moves.
// ---------------------------------------------------------------------------
module fpu_normalize_unit
  import fpu_pkg::*;
#(
  parameter int COARSE_STEP = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [MANT_W-1:0] in_mantissa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [2:0]        out_grs,
  output logic              out_zero,
  output logic              out_denormal,
  output logic              out_overflow
);

  norm_state_e state_q, state_d;

  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic        [MANT_W-1:0] mant_q, mant_d;

  ext_fp_t    out_data_q, out_data_d;
  logic [2:0] out_grs_q, out_grs_d;
  logic       zero_q, zero_d;
  logic       denorm_q, denorm_d;
  logic       ovf_q, ovf_d;

  logic        [MANT_W-1:0] step_mant;
  logic signed [EXP_W-1:0]  step_exp;
  norm_term_e               step_term;

  fpu_norm_step #(
    .COARSE_STEP(COARSE_STEP)
  ) u_step (
    .mant_i(mant_q),
    .exp_i (exp_q),
    .mant_o(step_mant),
    .exp_o (step_exp),
    .term_o(step_term)
  );

  // State and data registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      out_data_q <= '0;
      out_grs_q  <= '0;
      zero_q     <= 1'b0;
      denorm_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      out_data_q <= out_data_d;
      out_grs_q  <= out_grs_d;
      zero_q     <= zero_d;
      denorm_q   <= denorm_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)               state_d = SHIFT;
      SHIFT:   if (step_term != TERM_NONE) state_d = DONE;
      DONE:    if (out_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath: load operand, iterate, capture the result on the terminal
  // step. Result registers only change in SHIFT, so DONE holds them stable.
  always_comb begin
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    out_data_d = out_data_q;
    out_grs_d  = out_grs_q;
    zero_d     = zero_q;
    denorm_d   = denorm_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exponent;
          mant_d = in_mantissa;
        end
      end
      SHIFT: begin
        mant_d = step_mant;
        exp_d  = step_exp;
        if (step_term != TERM_NONE) begin
          out_data_d = '{sign: sign_q, exp: exp_q[XEXP_W-1:0],
                         sig: mant_q[EXT_INT_BIT -: SIG_W]};
          out_grs_d  = mant_q[2:0];
          zero_d     = 1'b0;
          denorm_d   = 1'b0;
          ovf_d      = 1'b0;
          case (step_term)
            TERM_ZERO: begin
              out_data_d = '{sign: sign_q, exp: '0, sig: '0};
              out_grs_d  = '0;
              zero_d     = 1'b1;
            end
            TERM_OVF: begin
              out_data_d = '{sign: sign_q, exp: EXT_EXP_MAX, sig: EXT_SIG_INF};
              out_grs_d  = '0;
              ovf_d      = 1'b1;
            end
            TERM_DENORM: begin
              out_data_d.exp = '0;
              denorm_d       = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready     = (state_q == IDLE);
    out_valid    = (state_q == DONE);
    out_data     = out_data_q;
    out_grs      = out_grs_q;
    out_zero     = zero_q;
    out_denormal = denorm_q;
    out_overflow = ovf_q;
  end

endmodule

// File: tb/tb_fpu_normalize_unit.sv
// ---------------------------------------------------------------------------
// tb_fpu_normalize_unit
// Scoreboard bench for fpu_normalize_unit: expected results are queued as
// each operand is driven and popped when the DUT presents out_valid.
// Latency is counted in rising edges with the accepting edge as edge 1.
// ---------------------------------------------------------------------------
module tb_fpu_normalize_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [16:0] in_exponent;
  logic [67:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;
  logic [2:0]  out_grs;
  logic        out_zero;
  logic        out_denormal;
  logic        out_overflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        s;
    logic [16:0] e;
    logic [67:0] m;
    logic [79:0] d;
    logic [2:0]  g;
    logic [2:0]  f;    // {zero, denormal, overflow}
    int          lat;
  } vec_t;

  vec_t sb[$];

`ifdef FPU_NORM_COARSE_SHIFT_EN
  localparam int LAT_LEFT63 = 16;
  localparam int LAT_COARSE = 3;
`else
  localparam int LAT_LEFT63 = 65;
  localparam int LAT_COARSE = 10;
`endif

  localparam logic [63:0] SIG_MSB = 64'h8000_0000_0000_0000;

  fpu_normalize_unit #(.COARSE_STEP(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_grs     (out_grs),
    .out_zero    (out_zero),
    .out_denormal(out_denormal),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Offer one operand, then wait (bounded) for out_valid.
  task automatic drive_op(input logic s, input logic [16:0] e,
                          input logic [67:0] m, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_sign = s; in_exponent = e; in_mantissa = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exponent = '0; in_mantissa = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_data, out_grs, out_zero, out_denormal, out_overflow}
        !== {1'b0, 1'b1, 80'h0, 3'b0, 3'b0}) begin
      n_err++;
      $display("FAIL reset: got valid=%b ready=%b data=%h grs=%b flags=%b%b%b want 0 1 0 0 000",
               out_valid, in_ready, out_data, out_grs, out_zero, out_denormal, out_overflow);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t tbl[$];
    vec_t x;
    int   lat;
    // normalized already
    tbl.push_back('{1'b0, 17'h03FFF, 68'h4_0000_0000_0000_0000,
                    {1'b0, 15'h3FFF, SIG_MSB}, 3'b000, 3'b000, 2});
    // carry set: one right shift, sticky from bit0
    tbl.push_back('{1'b0, 17'h03FFF, 68'h8_0000_0000_0000_0001,
                    {1'b0, 15'h4000, SIG_MSB}, 3'b001, 3'b000, 3});
    // bit3 only: 63 left shifts
    tbl.push_back('{1'b0, 17'h03FFF, 68'h0_0000_0000_0000_0008,
                    {1'b0, 15'h3FC0, SIG_MSB}, 3'b000, 3'b000, LAT_LEFT63});
    // bit63 at exp 3: two left shifts reach exp 1 with bit65 -> denormal
    tbl.push_back('{1'b0, 17'h00003, 68'h0_8000_0000_0000_0000,
                    {1'b0, 15'h0000, 64'h4000_0000_0000_0000}, 3'b000, 3'b010, 4});
    // exponent at max: overflow to infinity
    tbl.push_back('{1'b1, 17'h07FFF, 68'h4_0000_0000_0000_0000,
                    {1'b1, 15'h7FFF, SIG_MSB}, 3'b000, 3'b001, 2});
    // negative zero
    tbl.push_back('{1'b1, 17'h03FFF, 68'h0,
                    {1'b1, 15'h0000, 64'h0}, 3'b000, 3'b100, 2});
    // exp -2: three sticky right shifts to exp 1, bit63 -> denormal
    tbl.push_back('{1'b0, 17'h1FFFE, 68'h4_0000_0000_0000_0001,
                    {1'b0, 15'h0000, 64'h1000_0000_0000_0000}, 3'b001, 3'b010, 5});
    // exp -100: collapses to sticky-only in one step, then denormal
    tbl.push_back('{1'b1, 17'h1FF9C, 68'h4_0000_0000_0000_0000,
                    {1'b1, 15'h0000, 64'h0}, 3'b001, 3'b010, 3});
    // exp 9, bit58: coarse step allowed (9 > 8), ends normal at exp 1
    tbl.push_back('{1'b0, 17'h00009, 68'h0_0400_0000_0000_0000,
                    {1'b0, 15'h0001, SIG_MSB}, 3'b000, 3'b000, LAT_COARSE});
    // exp 8, bit58: coarse not allowed (8 > 8 false), 7 shifts -> denormal
    tbl.push_back('{1'b0, 17'h00008, 68'h0_0400_0000_0000_0000,
                    {1'b0, 15'h0000, 64'h4000_0000_0000_0000}, 3'b000, 3'b010, 9});

    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      drive_op(tbl[i].s, tbl[i].e, tbl[i].m, lat);
      x = sb.pop_front();
      n_vec++;
      if (lat !== x.lat) begin
        n_err++;
        $display("FAIL vec%0d latency: got %0d want %0d", i, lat, x.lat);
      end
      n_vec++;
      if (out_data !== x.d) begin
        n_err++;
        $display("FAIL vec%0d data: got %h want %h", i, out_data, x.d);
      end
      n_vec++;
      if (out_grs !== x.g) begin
        n_err++;
        $display("FAIL vec%0d grs: got %b want %b", i, out_grs, x.g);
      end
      n_vec++;
      if ({out_zero, out_denormal, out_overflow} !== x.f) begin
        n_err++;
        $display("FAIL vec%0d flags(z,d,o): got %b want %b", i,
                 {out_zero, out_denormal, out_overflow}, x.f);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    vec_t x;
    int   lat;
    int   w;
    sb.push_back('{1'b1, 17'h01234, 68'h4_0000_0000_0000_0004,
                   {1'b1, 15'h1234, SIG_MSB}, 3'b100, 3'b000, 2});
    drive_op(1'b1, 17'h01234, 68'h4_0000_0000_0000_0004, lat);
    x = sb.pop_front();
    // a new operand is offered while the result waits; it must be ignored
    in_sign = 1'b0; in_exponent = 17'h00100; in_mantissa = '0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if ({out_valid, in_ready, out_data, out_grs} !== {1'b1, 1'b0, x.d, x.g}) begin
        n_err++;
        $display("FAIL hold%0d: got valid=%b ready=%b data=%h grs=%b want 1 0 %h %b",
                 c, out_valid, in_ready, out_data, out_grs, x.d, x.g);
      end
      @(posedge clk); #1;
    end
    release_out();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    // the held operand is taken on the following edge
    sb.push_back('{1'b0, 17'h00100, 68'h0, {1'b0, 15'h0, 64'h0}, 3'b000, 3'b100, 2});
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
    x = sb.pop_front();
    n_vec++;
    if ({out_valid, out_data, out_zero} !== {1'b1, x.d, 1'b1}) begin
      n_err++;
      $display("FAIL held_operand: got valid=%b data=%h zero=%b want 1 %h 1",
               out_valid, out_data, out_zero, x.d);
    end
    release_out();
  endtask

  task automatic test_reset_mid_shift();
    vec_t x;
    int   lat;
    bit   seen = 0;
    in_sign = 1'b0; in_exponent = 17'h03FFF; in_mantissa = 68'h8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 80'h0}) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b ready=%b data=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL discarded_op: out_valid got %b want 0", seen);
    end
    sb.push_back('{1'b0, 17'h03FFF, 68'h8_0000_0000_0000_0001,
                   {1'b0, 15'h4000, SIG_MSB}, 3'b001, 3'b000, 3});
    drive_op(1'b0, 17'h03FFF, 68'h8_0000_0000_0000_0001, lat);
    x = sb.pop_front();
    n_vec++;
    if ({lat, out_data, out_grs} !== {x.lat, x.d, x.g}) begin
      n_err++;
      $display("FAIL post_reset: got lat=%0d data=%h grs=%b want %0d %h %b",
               lat, out_data, out_grs, x.lat, x.d, x.g);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
